// File: rtl/vram_pkg.sv
// Shared types and default geometry for the frame-buffer arbiter.
// Frame-lock behaviour is selected with VRAM_ARB_FRAME_LOCK_EN (see vram_arbiter).
package vram_pkg;

    localparam int DEF_IMG_W        = 640;
    localparam int DEF_IMG_H        = 480;
    localparam int DEF_PIX_W        = 4;
    localparam int DEF_STARVE_LIMIT = 1024;
    localparam int IMG_SIZE         = DEF_IMG_W * DEF_IMG_H;
    localparam int DEF_ADDR_W       = $clog2(IMG_SIZE);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_t;

    typedef logic [DEF_PIX_W-1:0]  pixel_t;
    typedef logic [DEF_ADDR_W-1:0] vram_addr_t;

endpackage

// File: rtl/vram_hold_buf.sv
// One-entry write holding register with range check and starvation monitor.
// Accept-to-commit 1 cycle minimum; wr_ready low while an entry is held.
// Commit happens only in cycles where wr_permit is high; otherwise the entry waits.
module vram_hold_buf
    import vram_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int PIX_W        = DEF_PIX_W,
    parameter int IMG_PIXELS   = IMG_SIZE,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              pixel_clk,
    input  logic              resetn_sync,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              wr_permit,
    output logic              wr_ready,
    output logic              commit,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [PIX_W-1:0]  hold_data,
    output logic              wr_done,
    output logic              wr_err,
    output logic              wr_starved
);

    localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT     = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

    hold_state_t      state, state_nxt;
    logic             capture;
    logic             err_nxt;
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge pixel_clk or negedge resetn_sync) begin
        if (!resetn_sync) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        err_nxt   = 1'b0;
        commit    = 1'b0;
        case (state)
            EMPTY: begin
                if (wr_valid) begin
                    capture = 1'b1;
                    if (wr_addr <= LAST_ADDR) begin
                        state_nxt = HELD;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            HELD: begin
                if (wr_permit) begin
                    commit    = 1'b1;
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge resetn_sync) begin
        if (!resetn_sync) begin
            hold_addr  <= '0;
            hold_data  <= '0;
            wr_ready   <= 1'b1;
            wr_done    <= 1'b0;
            wr_err     <= 1'b0;
            wr_starved <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (capture) begin
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end
            wr_ready   <= (state_nxt == EMPTY);
            wr_done    <= commit;
            wr_err     <= err_nxt;
            wr_starved <= wr_starved | (starve_cnt == LIMIT);
            // Counter only restarts when a new entry is accepted, so a starved
            // value survives the eventual commit until the flag is latched.
            if (state == EMPTY && state_nxt == HELD) begin
                starve_cnt <= '0;
            end else if (state == HELD && !commit && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the frame-buffer RAM port: scan-out reads win, buffered writes fill idle cycles.
// Read latency 2 cycles (rd_req -> rd_valid); reads never stall; writes wait in a one-entry buffer.
// Define VRAM_ARB_FRAME_LOCK_EN to restrict write commits to vertical blanking.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int IMG_W        = DEF_IMG_W,
    parameter int IMG_H        = DEF_IMG_H,
    parameter int PIX_W        = DEF_PIX_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    localparam int ADDR_W      = $clog2(IMG_W * IMG_H)
) (
    input  logic              pixel_clk,
    input  logic              resetn_sync,
    input  logic              vblank,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_done,
    output logic              wr_err,
    output logic              wr_starved,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata
);

    logic              wr_permit;
    logic              commit;
    logic [ADDR_W-1:0] hold_addr;
    logic [PIX_W-1:0]  hold_data;
    logic              rd_req_d1;

`ifdef VRAM_ARB_FRAME_LOCK_EN
    assign wr_permit = !rd_req && vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign wr_permit     = !rd_req;
`endif

    vram_hold_buf #(
        .ADDR_W       (ADDR_W),
        .PIX_W        (PIX_W),
        .IMG_PIXELS   (IMG_W * IMG_H),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_hold_buf (
        .pixel_clk   (pixel_clk),
        .resetn_sync (resetn_sync),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_permit   (wr_permit),
        .wr_ready    (wr_ready),
        .commit      (commit),
        .hold_addr   (hold_addr),
        .hold_data   (hold_data),
        .wr_done     (wr_done),
        .wr_err      (wr_err),
        .wr_starved  (wr_starved)
    );

    // commit already implies !rd_req, so the read branch never masks a commit.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = rd_addr;
        mem_wdata = hold_data;
        if (rd_req) begin
            mem_en = 1'b1;
        end else if (commit) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = hold_addr;
        end
    end

    always_ff @(posedge pixel_clk or negedge resetn_sync) begin
        if (!resetn_sync) begin
            rd_req_d1 <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_req_d1 <= rd_req;
            rd_valid  <= rd_req_d1;
            rd_data   <= mem_rdata;
        end
    end

endmodule
